dma_channel_scheduler: RTL and testbench

//  Arbitrates transfer requests from NUM_CH requesters and sequences one DMA transfer at a time.

---
 rtl/dma_channel_scheduler.sv | 179 +++++++++++++++++
 tb/tb_dma_channel_scheduler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dma_channel_scheduler.sv
// Round-robin DMA request arbiter that sequences one read/write master transfer at a time,
// guarded by a done-pulse watchdog, and reports a completion record per accepted request.
module dma_channel_scheduler #(
    parameter int NUM_CH      = 2,
    parameter int TIMEOUT_CYC = 65536,
    localparam int CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_CH-1:0]      i_req_valid,
    output logic [NUM_CH-1:0]      o_req_ready,
    input  logic [NUM_CH*32-1:0]   i_req_src,
    input  logic [NUM_CH*32-1:0]   i_req_dst,
    input  logic [NUM_CH*32-1:0]   i_req_len,
    output logic                   o_rd_start,
    output logic [31:0]            o_rd_src_addr,
    output logic                   o_wr_start,
    output logic [31:0]            o_wr_dst_addr,
    output logic [31:0]            o_xfer_len,
    input  logic                   i_read_done,
    input  logic                   i_write_done,
    output logic                   o_busy,
    output logic                   o_cmpl_valid,
    output logic [CHW-1:0]         o_cmpl_ch,
    output logic [1:0]             o_cmpl_status
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_CMPL} state_e;

    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ZERO    = 2'b01;
    localparam logic [1:0] ST_UNAL    = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    state_e          state_q, state_d;
    logic [CHW-1:0]  ptr_q, ptr_d;
    logic [CHW-1:0]  ch_q, ch_d;
    logic [31:0]     src_q, src_d, dst_q, dst_d, len_q, len_d;
    logic            rd_done_q, rd_done_d, wr_done_q, wr_done_d;
    logic [WDW-1:0]  wdog_q, wdog_d;
    logic [CHW-1:0]  cmpl_ch_q, cmpl_ch_d;
    logic [1:0]      cmpl_st_q, cmpl_st_d;

    logic [2*NUM_CH-1:0] req_dbl;
    logic [NUM_CH-1:0]   req_rot;
    logic                grant_vld;
    logic [CHW-1:0]      grant_idx;
    logic [NUM_CH-1:0]   grant_oh;
    logic [31:0]         sel_src, sel_dst, sel_len;

    // Rotate the request vector so bit 0 is the channel at the round-robin pointer.
    always_comb begin
        req_dbl   = {i_req_valid, i_req_valid};
        req_rot   = NUM_CH'(req_dbl >> ptr_q);
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req_rot[i] && !grant_vld) begin
                grant_vld = 1'b1;
                grant_idx = CHW'((int'(ptr_q) + i) % NUM_CH);
            end
        end
        grant_oh = '0;
        sel_src  = '0;
        sel_dst  = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_idx == CHW'(i)) begin
                grant_oh[i] = 1'b1;
                sel_src     = i_req_src[32*i +: 32];
                sel_dst     = i_req_dst[32*i +: 32];
                sel_len     = i_req_len[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ch_d        = ch_q;
        src_d       = src_q;
        dst_d       = dst_q;
        len_d       = len_q;
        rd_done_d   = rd_done_q;
        wr_done_d   = wr_done_q;
        wdog_d      = wdog_q;
        cmpl_ch_d   = cmpl_ch_q;
        cmpl_st_d   = cmpl_st_q;
        o_req_ready = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    o_req_ready = grant_oh;
                    ptr_d       = CHW'((int'(grant_idx) + 1) % NUM_CH);
                    ch_d        = grant_idx;
                    src_d       = sel_src;
                    dst_d       = sel_dst;
                    len_d       = sel_len;
                    // Rejected requests complete directly; the masters never see them.
                    if (sel_len == 32'd0) begin
                        state_d   = S_CMPL;
                        cmpl_ch_d = grant_idx;
                        cmpl_st_d = ST_ZERO;
                    end else if (|{sel_len[1:0], sel_src[1:0], sel_dst[1:0]}) begin
                        state_d   = S_CMPL;
                        cmpl_ch_d = grant_idx;
                        cmpl_st_d = ST_UNAL;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                rd_done_d = 1'b0;
                wr_done_d = 1'b0;
                wdog_d    = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                rd_done_d = rd_done_q | i_read_done;
                wr_done_d = wr_done_q | i_write_done;
                if (rd_done_d && wr_done_d) begin
                    state_d   = S_CMPL;
                    cmpl_ch_d = ch_q;
                    cmpl_st_d = ST_OK;
                end else if (wdog_q == WD_LAST) begin
                    state_d   = S_CMPL;
                    cmpl_ch_d = ch_q;
                    cmpl_st_d = ST_TIMEOUT;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_CMPL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            ch_q      <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            rd_done_q <= 1'b0;
            wr_done_q <= 1'b0;
            wdog_q    <= '0;
            cmpl_ch_q <= '0;
            cmpl_st_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            ch_q      <= ch_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            rd_done_q <= rd_done_d;
            wr_done_q <= wr_done_d;
            wdog_q    <= wdog_d;
            cmpl_ch_q <= cmpl_ch_d;
            cmpl_st_q <= cmpl_st_d;
        end
    end

    assign o_rd_start    = (state_q == S_START);
    assign o_wr_start    = (state_q == S_START);
    assign o_rd_src_addr = src_q;
    assign o_wr_dst_addr = dst_q;
    assign o_xfer_len    = len_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_cmpl_valid  = (state_q == S_CMPL);
    assign o_cmpl_ch     = cmpl_ch_q;
    assign o_cmpl_status = cmpl_st_q;

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Directed bench for dma_channel_scheduler: expected completion records are queued as each
// request is driven and compared when the completion pulse appears.
module tb_dma_channel_scheduler;

    localparam int NUM_CH = 2;
    localparam int TO     = 64;
    localparam logic [1:0] ST_OK = 2'b00, ST_ZERO = 2'b01, ST_UNAL = 2'b10, ST_TO = 2'b11;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [NUM_CH-1:0]    i_req_valid = '0;
    logic [NUM_CH-1:0]    o_req_ready;
    logic [NUM_CH*32-1:0] i_req_src = '0, i_req_dst = '0, i_req_len = '0;
    logic                 o_rd_start, o_wr_start;
    logic [31:0]          o_rd_src_addr, o_wr_dst_addr, o_xfer_len;
    logic                 i_read_done = 1'b0, i_write_done = 1'b0;
    logic                 o_busy, o_cmpl_valid;
    logic [0:0]           o_cmpl_ch;
    logic [1:0]           o_cmpl_status;

    dma_channel_scheduler #(.NUM_CH(NUM_CH), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_src(i_req_src), .i_req_dst(i_req_dst), .i_req_len(i_req_len),
        .o_rd_start(o_rd_start), .o_rd_src_addr(o_rd_src_addr),
        .o_wr_start(o_wr_start), .o_wr_dst_addr(o_wr_dst_addr), .o_xfer_len(o_xfer_len),
        .i_read_done(i_read_done), .i_write_done(i_write_done),
        .o_busy(o_busy), .o_cmpl_valid(o_cmpl_valid),
        .o_cmpl_ch(o_cmpl_ch), .o_cmpl_status(o_cmpl_status)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [0:0] ch;
        logic [1:0] st;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0, failures = 0;
    int rd_starts = 0, wr_starts = 0, cmpls = 0, cyc = 0, req_cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (o_rd_start) rd_starts++;
        if (o_wr_start) wr_starts++;
        if (o_cmpl_valid) cmpls++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [NUM_CH-1:0] mask, input int grant,
                          input logic [31:0] src, input logic [31:0] dst,
                          input logic [31:0] len, input logic [1:0] st);
        exp_t e;
        for (int i = 0; i < 10 && o_busy; i++) @(negedge clk);
        chk("idle_before_req", o_busy, 1'b0);
        for (int c = 0; c < NUM_CH; c++) begin
            i_req_src[32*c +: 32] = src;
            i_req_dst[32*c +: 32] = dst;
            i_req_len[32*c +: 32] = len;
        end
        i_req_valid = mask;
        #1;
        chk("req_ready", o_req_ready, NUM_CH'(1) << grant);
        e.ch = 1'(grant);
        e.st = st;
        exp_q.push_back(e);
        @(negedge clk);
        i_req_valid = '0;
        req_cyc = cyc;
    endtask

    task automatic pulse_done(input logic rd, input logic wr);
        i_read_done  = rd;
        i_write_done = wr;
        @(negedge clk);
        i_read_done  = 1'b0;
        i_write_done = 1'b0;
    endtask

    task automatic wait_cmpl(input int budget, output int lat);
        exp_t e;
        for (int i = 0; i < budget && !o_cmpl_valid; i++) @(negedge clk);
        lat = cyc - req_cyc;
        chk("cmpl_seen", o_cmpl_valid, 1'b1);
        if (o_cmpl_valid) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL cmpl_unexpected observed=1 expected=0");
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cmpl_ch", o_cmpl_ch, e.ch);
                chk("cmpl_status", o_cmpl_status, e.st);
            end
        end
        @(negedge clk);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ready"}, o_req_ready, '0);
        chk({tag, "_start"}, {o_rd_start, o_wr_start}, 2'b00);
        chk({tag, "_addr"}, {o_rd_src_addr, o_wr_dst_addr}, 64'd0);
        chk({tag, "_len"}, o_xfer_len, 32'd0);
        chk({tag, "_busy_cmpl"}, {o_busy, o_cmpl_valid}, 2'b00);
        chk({tag, "_cmpl_rec"}, {o_cmpl_ch, o_cmpl_status}, 3'b000);
    endtask

    initial begin
        int lat, s_rd, s_wr, c0;

        // Reset
        repeat (2) @(negedge clk);
        #1 chk_outputs_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Round robin from pointer 0, using zero-length requests for quick turnaround
        do_req(2'b11, 0, 32'h10, 32'h20, 32'd0, ST_ZERO); wait_cmpl(4, lat);
        do_req(2'b11, 1, 32'h10, 32'h20, 32'd0, ST_ZERO); wait_cmpl(4, lat);
        do_req(2'b10, 1, 32'h10, 32'h20, 32'd0, ST_ZERO); wait_cmpl(4, lat);
        do_req(2'b11, 0, 32'h10, 32'h20, 32'd0, ST_ZERO); wait_cmpl(4, lat);

        // Basic transfer on ch0: read done, write done 40 cycles later
        s_rd = rd_starts;
        do_req(2'b01, 0, 32'h1000, 32'h2000, 32'd256, ST_OK);
        chk("t1_start", {o_rd_start, o_wr_start}, 2'b11);
        chk("t1_src", o_rd_src_addr, 32'h1000);
        chk("t1_dst", o_wr_dst_addr, 32'h2000);
        chk("t1_len", o_xfer_len, 32'd256);
        @(negedge clk);
        pulse_done(1'b1, 1'b0);
        repeat (40) @(negedge clk);
        chk("t1_busy_wait", {o_busy, o_cmpl_valid}, 2'b10);
        chk("t1_src_hold", o_rd_src_addr, 32'h1000);
        pulse_done(1'b0, 1'b1);
        wait_cmpl(5, lat);
        chk("t1_busy_after", o_busy, 1'b0);
        chk("t1_start_count", rd_starts - s_rd, 1);

        // Zero length on ch1: completes fast, masters untouched
        s_rd = rd_starts; s_wr = wr_starts;
        do_req(2'b10, 1, 32'h3000, 32'h4000, 32'd0, ST_ZERO);
        wait_cmpl(3, lat);
        repeat (3) @(negedge clk);
        chk("zero_no_start", {rd_starts - s_rd, wr_starts - s_wr}, 64'd0);

        // Misaligned length and destination are rejected; next legal request runs
        do_req(2'b01, 0, 32'h1000, 32'h2000, 32'd6, ST_UNAL);  wait_cmpl(3, lat);
        do_req(2'b10, 1, 32'h1000, 32'h2002, 32'd64, ST_UNAL); wait_cmpl(3, lat);
        repeat (2) @(negedge clk);
        chk("unal_no_start", {rd_starts - s_rd, wr_starts - s_wr}, 64'd0);
        do_req(2'b01, 0, 32'h5000, 32'h6000, 32'd16, ST_OK);
        chk("legal_start", {o_rd_start, o_wr_start}, 2'b11);
        chk("legal_src", o_rd_src_addr, 32'h5000);
        @(negedge clk);
        pulse_done(1'b0, 1'b1);
        pulse_done(1'b1, 1'b0);
        wait_cmpl(5, lat);

        // Both dones in the same cycle give exactly one completion
        do_req(2'b10, 1, 32'h5100, 32'h6100, 32'd4, ST_OK);
        @(negedge clk);
        pulse_done(1'b1, 1'b1);
        wait_cmpl(3, lat);
        c0 = cmpls;
        repeat (5) @(negedge clk);
        chk("same_cycle_single_cmpl", cmpls - c0, 0);

        // Read done while idle is ignored; write done only -> timeout after TO wait cycles
        pulse_done(1'b1, 1'b0);
        do_req(2'b01, 0, 32'h7000, 32'h8000, 32'd128, ST_TO);
        @(negedge clk);
        pulse_done(1'b0, 1'b1);
        wait_cmpl(TO + 20, lat);
        chk("timeout_latency", lat, TO + 1);

        // Reset during WAIT clears outputs at once and the pointer back to 0
        do_req(2'b01, 0, 32'h9000, 32'hA000, 32'd32, ST_OK);
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", o_busy, 1'b1);
        reset_n = 1'b0;
        #1 chk_outputs_zero("midreset");
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_req(2'b11, 0, 32'hB000, 32'hC000, 32'd8, ST_OK);
        chk("post_reset_src", o_rd_src_addr, 32'hB000);
        @(negedge clk);
        pulse_done(1'b1, 1'b1);
        wait_cmpl(5, lat);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
